// File: rtl/draw_scheduler.sv
// Arbitrates the shared draw engine between the press and garbage movers: erase old position, draw new one.
// Optional: DRAW_SCHED_SAME_POS_SKIP_EN acks a move to the already-drawn position without touching the engine.
module draw_scheduler #(
   parameter int PRESS_PIX = 2400,
   parameter int GARB_PIX  = 400,
   parameter int CNT_W     = 12
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       press_req,
   input  logic [2:0] press_pos,
   input  logic       garbage_req,
   input  logic [2:0] garbage_pos,
   output logic       press_ack,
   output logic       garbage_ack,
   output logic       eng_item,
   output logic       eng_erase,
   output logic [2:0] eng_pos,
   output logic       eng_rst_n,
   output logic       plot_en,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      SYNC_E,
      ERASE,
      SYNC_D,
      DRAW,
      ACK
`ifdef DRAW_SCHED_SAME_POS_SKIP_EN
      , SKIP
`endif
   } state_t;

   state_t           state_q;
   logic [2:0]       pressCur_q;
   logic [2:0]       garbageCur_q;
   logic             pressVld_q;
   logic             garbageVld_q;
   logic             last_q;
   logic             jobItem_q;
   logic [2:0]       jobPos_q;
   logic [CNT_W-1:0] cnt_q;
   logic             engRstN_q;
   logic             plotEn_q;
   logic             engItem_q;
   logic             engErase_q;
   logic [2:0]       engPos_q;
   logic             pressAck_q;
   logic             garbageAck_q;
   logic             busy_q;

   logic             grantPress;
   logic [2:0]       selPos;
   logic [2:0]       selCur;
   logic             selVld;
   logic [CNT_W-1:0] phaseLast;

   // On a tie the requester that was not served last wins; item encoding 1 = press.
   assign grantPress = press_req & (~garbage_req | ~last_q);
   assign selPos     = grantPress ? press_pos    : garbage_pos;
   assign selCur     = grantPress ? pressCur_q   : garbageCur_q;
   assign selVld     = grantPress ? pressVld_q   : garbageVld_q;
   assign phaseLast  = jobItem_q ? CNT_W'(PRESS_PIX - 1) : CNT_W'(GARB_PIX - 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pressCur_q   <= 3'd0;
         garbageCur_q <= 3'd0;
         pressVld_q   <= 1'b0;
         garbageVld_q <= 1'b0;
         last_q       <= 1'b0;
         jobItem_q    <= 1'b0;
         jobPos_q     <= 3'd0;
         cnt_q        <= '0;
         engRstN_q    <= 1'b0;
         plotEn_q     <= 1'b0;
         engItem_q    <= 1'b0;
         engErase_q   <= 1'b0;
         engPos_q     <= 3'd0;
         pressAck_q   <= 1'b0;
         garbageAck_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         pressAck_q   <= 1'b0;
         garbageAck_q <= 1'b0;
         case (state_q)
            IDLE: begin
               engRstN_q <= 1'b1;
               plotEn_q  <= 1'b0;
               if (press_req || garbage_req) begin
                  jobItem_q <= grantPress;
                  jobPos_q  <= selPos;
                  engItem_q <= grantPress;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
`ifdef DRAW_SCHED_SAME_POS_SKIP_EN
                  if (selVld && (selCur == selPos)) begin
                     state_q <= SKIP;
                  end else
`endif
                  if (selVld) begin
                     state_q    <= SYNC_E;
                     engRstN_q  <= 1'b0;
                     engErase_q <= 1'b1;
                     engPos_q   <= selCur;
                  end else begin
                     state_q    <= SYNC_D;
                     engRstN_q  <= 1'b0;
                     engErase_q <= 1'b0;
                     engPos_q   <= selPos;
                  end
               end
            end
            SYNC_E: begin
               engRstN_q <= 1'b1;
               plotEn_q  <= 1'b1;
               state_q   <= ERASE;
            end
            ERASE: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == phaseLast) begin
                  state_q    <= SYNC_D;
                  cnt_q      <= '0;
                  plotEn_q   <= 1'b0;
                  engRstN_q  <= 1'b0;
                  engErase_q <= 1'b0;
                  engPos_q   <= jobPos_q;
               end
            end
            SYNC_D: begin
               engRstN_q <= 1'b1;
               plotEn_q  <= 1'b1;
               state_q   <= DRAW;
            end
            DRAW: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == phaseLast) begin
                  state_q      <= ACK;
                  cnt_q        <= '0;
                  plotEn_q     <= 1'b0;
                  pressAck_q   <= jobItem_q;
                  garbageAck_q <= ~jobItem_q;
               end
            end
`ifdef DRAW_SCHED_SAME_POS_SKIP_EN
            // One quiet cycle keeps the skipped ack at the same latency as a SYNC cycle.
            SKIP: begin
               state_q      <= ACK;
               pressAck_q   <= jobItem_q;
               garbageAck_q <= ~jobItem_q;
            end
`endif
            ACK: begin
               if (jobItem_q) begin
                  pressCur_q <= jobPos_q;
                  pressVld_q <= 1'b1;
               end else begin
                  garbageCur_q <= jobPos_q;
                  garbageVld_q <= 1'b1;
               end
               last_q  <= jobItem_q;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign press_ack   = pressAck_q;
   assign garbage_ack = garbageAck_q;
   assign eng_item    = engItem_q;
   assign eng_erase   = engErase_q;
   assign eng_pos     = engPos_q;
   assign eng_rst_n   = engRstN_q;
   assign plot_en     = plotEn_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: job latencies, erase/draw phases, arbitration, reset mid-job.
// Expected values for a repeated same-position job depend on DRAW_SCHED_SAME_POS_SKIP_EN.
module tb_draw_scheduler;

   logic       clk;
   logic       reset_n;
   logic       press_req;
   logic [2:0] press_pos;
   logic       garbage_req;
   logic [2:0] garbage_pos;
   logic       press_ack;
   logic       garbage_ack;
   logic       eng_item;
   logic       eng_erase;
   logic [2:0] eng_pos;
   logic       eng_rst_n;
   logic       plot_en;
   logic       busy;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct packed {
      int ackCycle;
      int extraAcks;
      int otherAcks;
      int plotCount;
      int firstPlot;
      int lastPlot;
      int erasePlots;
      int erasePosBad;
      int drawPosBad;
      int itemBad;
      int rstLowCount;
      int rstLow0;
      int rstLow1;
      int busyBad;
      int idleBusy;
   } jobStats_t;

   draw_scheduler dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .press_req   (press_req),
      .press_pos   (press_pos),
      .garbage_req (garbage_req),
      .garbage_pos (garbage_pos),
      .press_ack   (press_ack),
      .garbage_ack (garbage_ack),
      .eng_item    (eng_item),
      .eng_erase   (eng_erase),
      .eng_pos     (eng_pos),
      .eng_rst_n   (eng_rst_n),
      .plot_en     (plot_en),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Raise one request, count cycles from the sampling IDLE cycle (cycle 0) and
   // gather what the engine interface did until two cycles past the ack.
   task automatic runJob(input logic isPress, input logic [2:0] pos, input logic [2:0] erasePos,
                         input int dropAt, input int maxCycles, output jobStats_t s);
      int   c;
      int   stopAt;
      logic mine;
      logic other;
      s = '0;
      s.ackCycle  = -1;
      s.firstPlot = -1;
      s.lastPlot  = -1;
      @(negedge clk);
      if (isPress) begin press_req = 1'b1; press_pos = pos; end
      else begin garbage_req = 1'b1; garbage_pos = pos; end
      c = 0;
      stopAt = maxCycles;
      while (c < stopAt) begin
         @(negedge clk);
         c++;
         mine  = isPress ? press_ack : garbage_ack;
         other = isPress ? garbage_ack : press_ack;
         if (!eng_rst_n) begin
            if (s.rstLowCount == 0) s.rstLow0 = c;
            if (s.rstLowCount == 1) s.rstLow1 = c;
            s.rstLowCount++;
         end
         if (plot_en) begin
            s.plotCount++;
            if (s.firstPlot < 0) s.firstPlot = c;
            s.lastPlot = c;
            if (eng_item !== isPress) s.itemBad++;
            if (eng_erase) begin
               s.erasePlots++;
               if (eng_pos !== erasePos) s.erasePosBad++;
            end else if (eng_pos !== pos) begin
               s.drawPosBad++;
            end
         end
         if (s.ackCycle < 0 && busy !== 1'b1) s.busyBad++;
         if (s.ackCycle >= 0 && busy !== 1'b0) s.idleBusy++;
         if (other) s.otherAcks++;
         if (mine) begin
            if (s.ackCycle < 0) begin
               s.ackCycle = c;
               stopAt = c + 2;
            end else begin
               s.extraAcks++;
            end
            if (isPress) press_req = 1'b0; else garbage_req = 1'b0;
         end
         if (c == dropAt) begin
            if (isPress) press_req = 1'b0; else garbage_req = 1'b0;
         end
      end
      if (isPress) press_req = 1'b0; else garbage_req = 1'b0;
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [9:0] outs;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      outs = {eng_rst_n, plot_en, eng_item, eng_erase, eng_pos, press_ack, garbage_ack, busy};
      testsRun++;
      if (outs !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset outputs: got %b expected %b", outs, 10'd0); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      testsRun++;
      if (eng_rst_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle eng_rst_n: got %b expected 1", eng_rst_n); end
      testsRun++;
      if ({plot_en, busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL idle plot_en/busy: got %b expected 00", {plot_en, busy}); end
   endtask

   task automatic test_first_press();
      jobStats_t s;
      runJob(1'b1, 3'd2, 3'd0, 0, 6000, s);
      testsRun++;
      if (s.ackCycle !== 2402) begin testsFailed++; $display("[TB] FAIL first_press ack cycle: got %0d expected 2402", s.ackCycle); end
      testsRun++;
      if (s.plotCount !== 2400 || s.firstPlot !== 2 || s.lastPlot !== 2401) begin
         testsFailed++;
         $display("[TB] FAIL first_press plot window: got count %0d first %0d last %0d expected 2400 2 2401", s.plotCount, s.firstPlot, s.lastPlot);
      end
      testsRun++;
      if (s.erasePlots !== 0 || s.drawPosBad !== 0 || s.itemBad !== 0) begin
         testsFailed++;
         $display("[TB] FAIL first_press draw phase: got erase %0d badpos %0d baditem %0d expected 0 0 0", s.erasePlots, s.drawPosBad, s.itemBad);
      end
      testsRun++;
      if (s.rstLowCount !== 1 || s.rstLow0 !== 1) begin
         testsFailed++;
         $display("[TB] FAIL first_press eng_rst_n: got %0d lows first at %0d expected 1 low at 1", s.rstLowCount, s.rstLow0);
      end
      testsRun++;
      if (s.busyBad !== 0 || s.idleBusy !== 0 || s.extraAcks !== 0 || s.otherAcks !== 0) begin
         testsFailed++;
         $display("[TB] FAIL first_press busy/acks: got %0d %0d %0d %0d expected 0 0 0 0", s.busyBad, s.idleBusy, s.extraAcks, s.otherAcks);
      end
   endtask

   task automatic test_second_press();
      jobStats_t s;
      runJob(1'b1, 3'd1, 3'd2, 0, 6000, s);
      testsRun++;
      if (s.ackCycle !== 4803) begin testsFailed++; $display("[TB] FAIL second_press ack cycle: got %0d expected 4803", s.ackCycle); end
      testsRun++;
      if (s.erasePlots !== 2400 || s.plotCount !== 4800 || s.firstPlot !== 2 || s.lastPlot !== 4802) begin
         testsFailed++;
         $display("[TB] FAIL second_press phases: got erase %0d total %0d first %0d last %0d expected 2400 4800 2 4802",
                  s.erasePlots, s.plotCount, s.firstPlot, s.lastPlot);
      end
      testsRun++;
      if (s.erasePosBad !== 0 || s.drawPosBad !== 0 || s.itemBad !== 0) begin
         testsFailed++;
         $display("[TB] FAIL second_press positions: got %0d %0d %0d expected 0 0 0", s.erasePosBad, s.drawPosBad, s.itemBad);
      end
      testsRun++;
      if (s.rstLowCount !== 2 || s.rstLow0 !== 1 || s.rstLow1 !== 2402) begin
         testsFailed++;
         $display("[TB] FAIL second_press eng_rst_n: got %0d lows at %0d,%0d expected 2 lows at 1,2402", s.rstLowCount, s.rstLow0, s.rstLow1);
      end
   endtask

   task automatic test_same_pos();
      jobStats_t s;
      int expAck;
      int expPlots;
`ifdef DRAW_SCHED_SAME_POS_SKIP_EN
      expAck   = 2;
      expPlots = 0;
`else
      expAck   = 4803;
      expPlots = 4800;
`endif
      runJob(1'b1, 3'd1, 3'd1, 0, 6000, s);
      testsRun++;
      if (s.ackCycle !== expAck) begin testsFailed++; $display("[TB] FAIL same_pos ack cycle: got %0d expected %0d", s.ackCycle, expAck); end
      testsRun++;
      if (s.plotCount !== expPlots) begin testsFailed++; $display("[TB] FAIL same_pos plot cycles: got %0d expected %0d", s.plotCount, expPlots); end
   endtask

   task automatic test_reset_mid_job();
      jobStats_t  s;
      logic [9:0] outs;
      int         sawAck;
      @(negedge clk);
      garbage_req = 1'b1;
      garbage_pos = 3'd3;
      for (int c = 1; c <= 101; c++) @(negedge clk);
      testsRun++;
      if ({plot_en, eng_erase, eng_pos} !== 5'b1_0_011) begin
         testsFailed++;
         $display("[TB] FAIL mid_job drawing: got %b expected 10011", {plot_en, eng_erase, eng_pos});
      end
      reset_n = 1'b0;
      #1;
      outs = {eng_rst_n, plot_en, eng_item, eng_erase, eng_pos, press_ack, garbage_ack, busy};
      testsRun++;
      if (outs !== 10'd0) begin testsFailed++; $display("[TB] FAIL mid_job async reset: got %b expected %b", outs, 10'd0); end
      garbage_req = 1'b0;
      sawAck = 0;
      repeat (3) begin @(negedge clk); if (press_ack || garbage_ack) sawAck++; end
      reset_n = 1'b1;
      repeat (4) begin @(negedge clk); if (press_ack || garbage_ack || busy) sawAck++; end
      testsRun++;
      if (sawAck !== 0) begin testsFailed++; $display("[TB] FAIL mid_job no ack: got %0d ack/busy cycles expected 0", sawAck); end
      runJob(1'b0, 3'd3, 3'd0, 0, 2000, s);
      testsRun++;
      if (s.ackCycle !== 402) begin testsFailed++; $display("[TB] FAIL after_reset ack cycle: got %0d expected 402", s.ackCycle); end
      testsRun++;
      if (s.erasePlots !== 0 || s.plotCount !== 400 || s.drawPosBad !== 0) begin
         testsFailed++;
         $display("[TB] FAIL after_reset phases: got erase %0d total %0d badpos %0d expected 0 400 0", s.erasePlots, s.plotCount, s.drawPosBad);
      end
   endtask

   task automatic test_drop_req();
      jobStats_t s;
      runJob(1'b0, 3'd5, 3'd3, 10, 2000, s);
      testsRun++;
      if (s.ackCycle !== 803) begin testsFailed++; $display("[TB] FAIL drop_req ack cycle: got %0d expected 803", s.ackCycle); end
      testsRun++;
      if (s.erasePlots !== 400 || s.plotCount !== 800 || s.erasePosBad !== 0 || s.drawPosBad !== 0 || s.itemBad !== 0) begin
         testsFailed++;
         $display("[TB] FAIL drop_req phases: got erase %0d total %0d bad %0d/%0d/%0d expected 400 800 0/0/0",
                  s.erasePlots, s.plotCount, s.erasePosBad, s.drawPosBad, s.itemBad);
      end
      testsRun++;
      if (s.idleBusy !== 0 || s.extraAcks !== 0 || s.rstLowCount !== 2) begin
         testsFailed++;
         $display("[TB] FAIL drop_req no second job: got busy %0d acks %0d rstlows %0d expected 0 0 2", s.idleBusy, s.extraAcks, s.rstLowCount);
      end
   endtask

   task automatic test_arbitration();
      int   n;
      int   both;
      int   ackCyc [3];
      logic ackIsPress [3];
      int   expThird;
`ifdef DRAW_SCHED_SAME_POS_SKIP_EN
      expThird = 2808;
`else
      expThird = 7609;
`endif
      applyReset();
      @(negedge clk);
      press_req   = 1'b1;
      press_pos   = 3'd5;
      garbage_req = 1'b1;
      garbage_pos = 3'd6;
      n = 0;
      both = 0;
      for (int c = 1; c <= 9000 && n < 3; c++) begin
         @(negedge clk);
         if (press_ack && garbage_ack) both++;
         if (press_ack || garbage_ack) begin
            ackCyc[n] = c;
            ackIsPress[n] = press_ack;
            n++;
         end
      end
      press_req   = 1'b0;
      garbage_req = 1'b0;
      testsRun++;
      if (n !== 3 || both !== 0) begin testsFailed++; $display("[TB] FAIL arb ack count: got %0d (overlap %0d) expected 3 (0)", n, both); end
      if (n == 3) begin
         testsRun++;
         if ({ackIsPress[0], ackIsPress[1], ackIsPress[2]} !== 3'b101) begin
            testsFailed++;
            $display("[TB] FAIL arb order: got %b expected 101", {ackIsPress[0], ackIsPress[1], ackIsPress[2]});
         end
         testsRun++;
         if (ackCyc[0] !== 2402 || ackCyc[1] !== 2805 || ackCyc[2] !== expThird) begin
            testsFailed++;
            $display("[TB] FAIL arb ack cycles: got %0d %0d %0d expected 2402 2805 %0d", ackCyc[0], ackCyc[1], ackCyc[2], expThird);
         end
      end
      repeat (3) @(negedge clk);
      testsRun++;
      if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL arb idle after release: got busy %b expected 0", busy); end
   endtask

   initial begin
      reset_n     = 1'b0;
      press_req   = 1'b0;
      press_pos   = 3'd0;
      garbage_req = 1'b0;
      garbage_pos = 3'd0;
      test_reset();
      test_first_press();
      test_second_press();
      test_same_pos();
      test_reset_mid_job();
      test_drop_req();
      test_arbitration();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
